// File: rtl/vp_kbd_pkg.sv
// Shared types and key-code constants for the keyboard event queue.
package vp_kbd_pkg;

    typedef struct packed {
        logic       released;
        logic [7:0] ascii;
    } kbd_evt_t;

    localparam logic [7:0] KEY_YES   = 8'h11;
    localparam logic [7:0] KEY_NO    = 8'h12;
    localparam logic [7:0] KEY_ENTER = 8'h0A;
    localparam logic [7:0] KEY_BS    = 8'h08;

    typedef enum logic [1:0] {StIdle, StPresent, StHold, StGap} kbd_state_t;

    // Numpad bit 0..8 -> "1".."9", bit 9 -> "0".
    function automatic logic [7:0] joy_ascii(input logic [3:0] idx);
        return (idx == 4'd9) ? 8'h30 : 8'h31 + {4'h0, idx};
    endfunction

endpackage

// File: rtl/vp_ps2_ascii_lut.sv
// PS/2 set-2 scan code to key code translation; codes without a mapping report valid=0.
module vp_ps2_ascii_lut
    import vp_kbd_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic       valid,
    output logic [7:0] ascii
);

    always_comb begin
        valid = 1'b1;
        ascii = 8'h00;
        case (scan_code)
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h1C: ascii = 8'h61;
            8'h32: ascii = 8'h62;
            8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;
            8'h24: ascii = 8'h65;
            8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;
            8'h33: ascii = 8'h68;
            8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;
            8'h42: ascii = 8'h6B;
            8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;
            8'h31: ascii = 8'h6E;
            8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;
            8'h15: ascii = 8'h71;
            8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;
            8'h2C: ascii = 8'h74;
            8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;
            8'h1D: ascii = 8'h77;
            8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;
            8'h1A: ascii = 8'h7A;
            8'h29: ascii = 8'h20;
            8'h79: ascii = 8'h2B;
            8'h4E: ascii = 8'h2D;
            8'h7C: ascii = 8'h2A;
            8'h4A: ascii = 8'h2F;
            8'h55: ascii = 8'h3D;
            8'h1F: ascii = KEY_YES;
            8'h27: ascii = KEY_NO;
            8'h5A: ascii = KEY_ENTER;
            8'h66: ascii = KEY_BS;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/vp_kbd_event_queue.sv
// Merges PS/2 toggles and joystick numpad edges into a paced press/release stream for vp_keymap.
module vp_kbd_event_queue
    import vp_kbd_pkg::*;
#(
    parameter int unsigned FIFO_AW      = 3,
    parameter int unsigned HOLD_TIMEOUT = 1_000_000,
    parameter int unsigned GAP_CYCLES   = 1024
) (
    input  logic             clk_i,
    input  logic             res_n_i,
    input  logic [10:0]      ps2_key_i,
    input  logic [9:0]       joy_numpad_i,
    input  logic             rx_read_i,
    output logic             rx_data_ready_o,
    output logic [7:0]       rx_ascii_o,
    output logic             rx_released_o,
    output logic [FIFO_AW:0] fifo_level_o,
    output logic             overflow_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned HW    = $clog2(HOLD_TIMEOUT + 1);
    localparam int unsigned GW    = $clog2(GAP_CYCLES + 1);
    localparam logic [FIFO_AW:0] PTR_ONE   = 1;
    localparam logic [HW-1:0]    HOLD_ONE  = 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TIMEOUT - 1);
    localparam logic [GW-1:0]    GAP_ONE   = 1;
    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYCLES - 1);

    logic             ps2_init, ps2_tog, ps2_new, lut_valid, unused_ext;
    logic [7:0]       lut_ascii;
    kbd_evt_t         ps2_pend, push_evt;
    logic             ps2_pend_valid, push_ps2, push, pop, full, empty, found;
    logic [9:0]       joy_hist, joy_flag, joy_rel, joy_grant;
    logic [FIFO_AW:0] wr_ptr, rd_ptr, level;
    kbd_evt_t         mem [DEPTH];
    kbd_state_t       state;
    logic [HW-1:0]    hold_cnt;
    logic [GW-1:0]    gap_cnt;

    vp_ps2_ascii_lut u_lut (
        .scan_code (ps2_key_i[7:0]),
        .valid     (lut_valid),
        .ascii     (lut_ascii)
    );

    assign unused_ext   = ps2_key_i[8];
    assign ps2_new      = ps2_init && (ps2_key_i[10] != ps2_tog) && lut_valid;
    assign level        = wr_ptr - rd_ptr;
    assign fifo_level_o = level;
    assign full         = (level == (FIFO_AW + 1)'(DEPTH));
    assign empty        = (level == '0);
    assign pop          = (state == StIdle) && !empty;
    assign push_ps2     = ps2_pend_valid && !full;
    assign push         = !full && (ps2_pend_valid || (|joy_flag));

    // PS/2 pending has priority; otherwise the lowest-index joystick flag is granted.
    always_comb begin
        found     = 1'b0;
        joy_grant = '0;
        push_evt  = ps2_pend;
        if (!ps2_pend_valid && !full) begin
            for (int i = 0; i < 10; i++) begin
                if (!found && joy_flag[i]) begin
                    found             = 1'b1;
                    joy_grant[i]      = 1'b1;
                    push_evt.released = joy_rel[i];
                    push_evt.ascii    = joy_ascii(4'(i));
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            ps2_init       <= 1'b0;
            ps2_tog        <= 1'b0;
            ps2_pend_valid <= 1'b0;
            ps2_pend       <= '0;
            joy_hist       <= '0;
            joy_flag       <= '0;
            joy_rel        <= '0;
            overflow_o     <= 1'b0;
        end else begin
            ps2_init <= 1'b1;
            ps2_tog  <= ps2_key_i[10];
            joy_hist <= joy_numpad_i;
            if (ps2_new) begin
                ps2_pend_valid    <= 1'b1;
                ps2_pend.released <= ~ps2_key_i[9];
                ps2_pend.ascii    <= lut_ascii;
                if (ps2_pend_valid && !push_ps2) overflow_o <= 1'b1;
            end else if (push_ps2) begin
                ps2_pend_valid <= 1'b0;
            end
            for (int i = 0; i < 10; i++) begin
                if (joy_numpad_i[i] ^ joy_hist[i]) begin
                    joy_flag[i] <= 1'b1;
                    joy_rel[i]  <= ~joy_numpad_i[i];
                end else if (joy_grant[i]) begin
                    joy_flag[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= push_evt;
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state           <= StIdle;
            rx_data_ready_o <= 1'b0;
            rx_ascii_o      <= '0;
            rx_released_o   <= 1'b0;
            hold_cnt        <= '0;
            gap_cnt         <= '0;
        end else begin
            rx_data_ready_o <= 1'b0;
            case (state)
                StIdle: begin
                    if (!empty) begin
                        rx_ascii_o    <= mem[rd_ptr[FIFO_AW-1:0]].ascii;
                        rx_released_o <= mem[rd_ptr[FIFO_AW-1:0]].released;
                        state         <= StPresent;
                    end
                end
                StPresent: begin
                    rx_data_ready_o <= 1'b1;
                    hold_cnt        <= '0;
                    state           <= StHold;
                end
                StHold: begin
                    if (rx_read_i || hold_cnt == HOLD_LAST) begin
                        gap_cnt <= GAP_LAST;
                        state   <= StGap;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                StGap: begin
                    if (gap_cnt == '0) state <= StIdle;
                    else               gap_cnt <= gap_cnt - GAP_ONE;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vp_kbd_event_queue.sv
// Directed bench for vp_kbd_event_queue: latency, joystick edges, burst queueing, overflow, reset.
module tb_vp_kbd_event_queue;

    localparam int unsigned GAP  = 1024;
    localparam int unsigned HOLD = 8;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [9:0]  joy = '0;
    logic        rx_read = 1'b0;
    logic        rx_data_ready;
    logic [7:0]  rx_ascii;
    logic        rx_released;
    logic [3:0]  fifo_level;
    logic        overflow;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned max_level = 0;
    logic [7:0]  ev_ascii[$];
    logic        ev_rel[$];
    int unsigned ev_cyc[$];

    vp_kbd_event_queue #(
        .FIFO_AW      (3),
        .HOLD_TIMEOUT (HOLD),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk_i           (clk),
        .res_n_i         (res_n),
        .ps2_key_i       (ps2_key),
        .joy_numpad_i    (joy),
        .rx_read_i       (rx_read),
        .rx_data_ready_o (rx_data_ready),
        .rx_ascii_o      (rx_ascii),
        .rx_released_o   (rx_released),
        .fifo_level_o    (fifo_level),
        .overflow_o      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data_ready) begin
            ev_ascii.push_back(rx_ascii);
            ev_rel.push_back(rx_released);
            ev_cyc.push_back(cyc);
        end
        if (32'(fifo_level) > max_level) max_level = 32'(fifo_level);
    end

    task automatic clear_events();
        ev_ascii.delete();
        ev_rel.delete();
        ev_cyc.delete();
        max_level = 0;
    endtask

    task automatic ps2_toggle(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic wait_events(input int n, input int budget, input string name);
        int waited = 0;
        while (ev_ascii.size() < n && waited < budget) begin
            @(negedge clk); #1;
            waited++;
        end
        checks++;
        if (ev_ascii.size() < n) begin
            failures++;
            $display("FAIL %s: got %0d events, required %0d", name, ev_ascii.size(), n);
        end
    endtask

    task automatic idle_wait();
        repeat (GAP + 50) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_data_ready, rx_ascii, rx_released, fifo_level, overflow} !== 15'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b ascii=%h rel=%b lvl=%0d ovf=%b, required all 0",
                     rx_data_ready, rx_ascii, rx_released, fifo_level, overflow);
        end
        res_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rx_data_ready !== 1'b0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL reset_idle: got rdy=%b lvl=%0d, required 0/0", rx_data_ready, fifo_level);
        end
    endtask

    task automatic test_ps2_latency();
        clear_events();
        ps2_toggle(8'h16, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_data_ready !== 1'b0) begin
            failures++;
            $display("FAIL lat_early: got rdy=%b at N+2, required 0", rx_data_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rx_data_ready !== 1'b1 || rx_ascii !== 8'h31 || rx_released !== 1'b0) begin
            failures++;
            $display("FAIL lat_press: got rdy=%b ascii=%h rel=%b, required 1/31/0",
                     rx_data_ready, rx_ascii, rx_released);
        end
        rx_read = 1'b1;
        @(posedge clk); #1;
        rx_read = 1'b0;
        checks++;
        if (rx_data_ready !== 1'b0 || rx_ascii !== 8'h31) begin
            failures++;
            $display("FAIL strobe_width: got rdy=%b ascii=%h, required 0/31", rx_data_ready, rx_ascii);
        end
        repeat (GAP + 20) @(posedge clk);
        #1;
        checks++;
        if (ev_ascii.size() != 1) begin
            failures++;
            $display("FAIL single_strobe: got %0d strobes, required 1", ev_ascii.size());
        end
        clear_events();
        ps2_toggle(8'h16, 1'b0);
        wait_events(1, 50, "release_wait");
        checks++;
        if (ev_ascii[0] !== 8'h31 || ev_rel[0] !== 1'b1) begin
            failures++;
            $display("FAIL ps2_release: got ascii=%h rel=%b, required 31/1", ev_ascii[0], ev_rel[0]);
        end
    endtask

    task automatic test_joystick();
        idle_wait();
        clear_events();
        joy = 10'h201;
        wait_events(2, 4000, "joy_press_wait");
        checks++;
        if (ev_ascii[0] !== 8'h31 || ev_rel[0] !== 1'b0 || ev_ascii[1] !== 8'h30 || ev_rel[1] !== 1'b0) begin
            failures++;
            $display("FAIL joy_press: got %h/%b %h/%b, required 31/0 30/0",
                     ev_ascii[0], ev_rel[0], ev_ascii[1], ev_rel[1]);
        end
        checks++;
        if (ev_cyc[1] - ev_cyc[0] < GAP) begin
            failures++;
            $display("FAIL joy_spacing: got %0d cycles, required >= %0d", ev_cyc[1] - ev_cyc[0], GAP);
        end
        clear_events();
        joy = 10'h000;
        wait_events(2, 4000, "joy_release_wait");
        checks++;
        if (ev_ascii[0] !== 8'h31 || ev_rel[0] !== 1'b1 || ev_ascii[1] !== 8'h30 || ev_rel[1] !== 1'b1) begin
            failures++;
            $display("FAIL joy_release: got %h/%b %h/%b, required 31/1 30/1",
                     ev_ascii[0], ev_rel[0], ev_ascii[1], ev_rel[1]);
        end
    endtask

    task automatic test_burst();
        logic [7:0] codes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        idle_wait();
        clear_events();
        for (int i = 0; i < 9; i++) begin
            ps2_toggle(codes[i], 1'b1);
            @(posedge clk); #1;
        end
        wait_events(9, 9 * (GAP + HOLD + 20), "burst_wait");
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ev_ascii[i] !== 8'h31 + 8'(i) || ev_rel[i] !== 1'b0) begin
                failures++;
                $display("FAIL burst_order[%0d]: got %h/%b, required %h/0",
                         i, ev_ascii[i], ev_rel[i], 8'h31 + 8'(i));
            end
        end
        checks++;
        if (max_level != 8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL burst_level: got peak=%0d ovf=%b, required 8/0", max_level, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [11] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42};
        logic [7:0] exp [10] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
                                 8'h6B};
        idle_wait();
        clear_events();
        for (int i = 0; i < 11; i++) begin
            ps2_toggle(codes[i], 1'b1);
            @(posedge clk); #1;
        end
        checks++;
        if (overflow !== 1'b1 || fifo_level !== 4'd8) begin
            failures++;
            $display("FAIL ovf_flag: got ovf=%b lvl=%0d, required 1/8", overflow, fifo_level);
        end
        wait_events(10, 10 * (GAP + HOLD + 20), "ovf_wait");
        repeat (GAP + 50) @(posedge clk);
        #1;
        checks++;
        if (ev_ascii.size() != 10) begin
            failures++;
            $display("FAIL ovf_count: got %0d events, required 10", ev_ascii.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ev_ascii[i] !== exp[i]) begin
                failures++;
                $display("FAIL ovf_order[%0d]: got %h, required %h", i, ev_ascii[i], exp[i]);
            end
        end
    endtask

    task automatic test_unmapped();
        idle_wait();
        clear_events();
        ps2_toggle(8'h76, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (ev_ascii.size() != 0 || max_level != 0) begin
            failures++;
            $display("FAIL unmapped: got %0d strobes peak=%0d, required 0/0", ev_ascii.size(), max_level);
        end
    endtask

    task automatic test_reset_mid();
        idle_wait();
        clear_events();
        ps2_toggle(8'h29, 1'b1); @(posedge clk); #1;
        ps2_toggle(8'h1F, 1'b1); @(posedge clk); #1;
        ps2_toggle(8'h5A, 1'b1); @(posedge clk); #1;
        ps2_toggle(8'h66, 1'b1);
        wait_events(1, 50, "mid_wait");
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fifo_level !== 4'd3 || rx_ascii !== 8'h20) begin
            failures++;
            $display("FAIL mid_hold: got lvl=%0d ascii=%h, required 3/20", fifo_level, rx_ascii);
        end
        res_n = 1'b0;
        #1;
        checks++;
        if ({rx_data_ready, rx_ascii, rx_released, fifo_level, overflow} !== 15'h0) begin
            failures++;
            $display("FAIL mid_reset: got rdy=%b ascii=%h rel=%b lvl=%0d ovf=%b, required all 0",
                     rx_data_ready, rx_ascii, rx_released, fifo_level, overflow);
        end
        repeat (3) @(posedge clk);
        #1;
        res_n = 1'b1;
        clear_events();
        repeat (2 * GAP) @(posedge clk);
        #1;
        checks++;
        if (ev_ascii.size() != 0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL post_reset: got %0d strobes lvl=%0d, required 0/0", ev_ascii.size(), fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_ps2_latency();
        test_joystick();
        test_burst();
        test_overflow();
        test_unmapped();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
